// File: rtl/pc_gen.sv
// Fetch-address generator: holds the fetch PC, issues aligned pair requests
// to the I-cache and merges exception / branch / predictor redirects.
module pc_gen #(
    parameter logic [31:0]     RESET_PC = 32'hBFC0_0000,
    localparam int unsigned    BR_WD    = 33
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             stall,
    input  logic [BR_WD-1:0] ex_bus,
    input  logic [BR_WD-1:0] br_bus,
    input  logic [BR_WD-1:0] bp_bus,
    output logic             if_req,
    output logic [31:0]      if_addr,
    input  logic             if_ack,
    output logic             if_epoch,
    output logic             cur_epoch,
    output logic [31:0]      current_pc1,
    output logic [31:0]      current_pc2
);

    localparam int unsigned AW  = 32;
    localparam int unsigned PRW = 2;

    localparam logic [PRW-1:0] PRI_BP = PRW'(0);
    localparam logic [PRW-1:0] PRI_BR = PRW'(1);
    localparam logic [PRW-1:0] PRI_EX = PRW'(2);

    // State is the (req, pend_v) pair; each bit is read directly below.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        IDLE_PEND = 2'b01,
        BUSY      = 2'b10,
        BUSY_PEND = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           req_epoch_q, req_epoch_d;
    logic           epoch_q, epoch_d;
    logic [PRW-1:0] pend_pri_q, pend_pri_d;
    logic [AW-1:0]  pend_pc_q, pend_pc_d;

    logic           req_q;
    logic           pend_v_q;
    logic           req_d;
    logic           pend_v_d;

    logic           ex_e, br_e, bp_e;
    logic [AW-1:0]  ex_target, br_target, bp_target;

    logic           rd_v_c;
    logic [PRW-1:0] rd_pri_c;
    logic [AW-1:0]  rd_pc_c;
    logic [AW-1:0]  seq_pc_c;
    logic           launch_c;

    assign req_q    = state_q[1];
    assign pend_v_q = state_q[0];

    assign ex_e      = ex_bus[BR_WD-1];
    assign ex_target = ex_bus[AW-1:0];
    assign br_e      = br_bus[BR_WD-1];
    assign br_target = br_bus[AW-1:0];
    assign bp_e      = bp_bus[BR_WD-1];
    assign bp_target = bp_bus[AW-1:0];

    // A new request may go out when the back end allows it and the slot is free.
    assign launch_c = !stall && (!req_q || if_ack);

    // Odd word of a pair steps by one word to realign, even word by a full pair.
    assign seq_pc_c = addr_q[2] ? (addr_q + AW'(4)) : (addr_q + AW'(8));

    // Pick the single highest-priority redirect of this cycle.
    always_comb begin
        rd_v_c   = 1'b0;
        rd_pri_c = PRI_BP;
        rd_pc_c  = '0;
        if (ex_e) begin
            rd_v_c   = 1'b1;
            rd_pri_c = PRI_EX;
            rd_pc_c  = ex_target;
        end else if (br_e) begin
            rd_v_c   = 1'b1;
            rd_pri_c = PRI_BR;
            rd_pc_c  = br_target;
        end else if (bp_e) begin
            rd_v_c   = 1'b1;
            rd_pri_c = PRI_BP;
            rd_pc_c  = bp_target;
        end
    end

    // Next-state: launch, hold an unacked request, or park a redirect.
    always_comb begin
        addr_d      = addr_q;
        req_d       = req_q;
        req_epoch_d = req_epoch_q;
        pend_v_d    = pend_v_q;
        pend_pri_d  = pend_pri_q;
        pend_pc_d   = pend_pc_q;
        epoch_d     = epoch_q ^ (ex_e | br_e);

        if (launch_c) begin
            req_d       = 1'b1;
            req_epoch_d = epoch_d;
            pend_v_d    = 1'b0;
            if (rd_v_c) begin
                addr_d = rd_pc_c;
            end else if (pend_v_q) begin
                addr_d = pend_pc_q;
            end else if (req_q) begin
                addr_d = seq_pc_c;
            end
        end else begin
            // Accepted while stalled: advance so the idle addr is the next fetch.
            if (req_q && if_ack) begin
                req_d  = 1'b0;
                addr_d = seq_pc_c;
            end
            if (rd_v_c && (!pend_v_q || (rd_pri_c >= pend_pri_q))) begin
                pend_v_d   = 1'b1;
                pend_pri_d = rd_pri_c;
                pend_pc_d  = rd_pc_c;
            end
        end

        state_d = state_t'({req_d, pend_v_d});
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= RESET_PC;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
            pend_pri_q  <= '0;
            pend_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            req_epoch_q <= req_epoch_d;
            epoch_q     <= epoch_d;
            pend_pri_q  <= pend_pri_d;
            pend_pc_q   <= pend_pc_d;
        end
    end

    assign if_req      = req_q;
    assign if_addr     = addr_q;
    assign if_epoch    = req_epoch_q;
    assign cur_epoch   = epoch_q;
    assign current_pc1 = addr_q;
    assign current_pc2 = addr_q + AW'(4);

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_gen;

    localparam logic [31:0] RST = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn, stall, if_ack;
    logic [32:0] ex_bus, br_bus, bp_bus;
    logic        if_req, if_epoch, cur_epoch;
    logic [31:0] if_addr, current_pc1, current_pc2;

    int checks = 0;
    int errors = 0;

    pc_gen dut (
        .clk        (clk),
        .resetn     (resetn),
        .stall      (stall),
        .ex_bus     (ex_bus),
        .br_bus     (br_bus),
        .bp_bus     (bp_bus),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_epoch   (if_epoch),
        .cur_epoch  (cur_epoch),
        .current_pc1(current_pc1),
        .current_pc2(current_pc2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: the "next fetch" address plus a single parked redirect slot.
    logic [31:0] m_addr, m_ppc, m_tgt;
    bit          m_req, m_ep, m_rep, m_pv, m_go, m_valid = 1'b0;
    int          m_ppri, m_hit;

    function automatic logic [31:0] next_seq(input logic [31:0] a);
        return (a & 32'hFFFF_FFF8) + 32'd8;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_addr = RST; m_req = 0; m_ep = 0; m_rep = 0;
            m_pv = 0; m_ppri = 0; m_ppc = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            m_hit = -1; m_tgt = 0;
            if (bp_bus[32]) begin m_hit = 0; m_tgt = bp_bus[31:0]; end
            if (br_bus[32]) begin m_hit = 1; m_tgt = br_bus[31:0]; end
            if (ex_bus[32]) begin m_hit = 2; m_tgt = ex_bus[31:0]; end
            if (ex_bus[32] || br_bus[32]) m_ep = !m_ep;
            m_go = !stall && (!m_req || if_ack);
            if (m_go) begin
                if (m_hit >= 0)  m_addr = m_tgt;
                else if (m_pv)   m_addr = m_ppc;
                else if (m_req)  m_addr = next_seq(m_addr);
                m_req = 1; m_rep = m_ep; m_pv = 0;
            end else begin
                if (m_req && if_ack) begin
                    m_addr = next_seq(m_addr);
                    m_req  = 0;
                end
                if (m_hit >= 0 && (!m_pv || m_hit >= m_ppri)) begin
                    m_pv = 1; m_ppri = m_hit; m_ppc = m_tgt;
                end
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_if_req",    32'(if_req),    32'(m_req));
            check("m_if_addr",   if_addr,        m_addr);
            check("m_if_epoch",  32'(if_epoch),  32'(m_rep));
            check("m_cur_epoch", 32'(cur_epoch), 32'(m_ep));
            check("m_pc1",       current_pc1,    m_addr);
            check("m_pc2",       current_pc2,    m_addr + 32'd4);
        end
    end

    function automatic logic [32:0] rand_bus(input int pct);
        logic [31:0] t;
        t = $urandom();
        t[1:0] = 2'b00;
        case ($urandom_range(0, 7))
            0: t = 32'hFFFF_FFF8;
            1: t = 32'hFFFF_FFFC;
            default: ;
        endcase
        return {($urandom_range(0, 99) < pct), t};
    endfunction

    initial begin
        resetn = 1'b0; stall = 1'b0; if_ack = 1'b0;
        ex_bus = '0; br_bus = '0; bp_bus = '0;
        repeat (2) @(negedge clk);
        check("rst_req",   32'(if_req),    32'd0);
        check("rst_addr",  if_addr,        RST);
        check("rst_epoch", 32'(cur_epoch), 32'd0);

        // Sequential pairs from reset.
        resetn = 1'b1; if_ack = 1'b1;
        @(negedge clk);
        check("seq0",     if_addr,     32'hBFC0_0000);
        check("seq0_req", 32'(if_req), 32'd1);
        check("seq0_pc2", current_pc2, 32'hBFC0_0004);
        @(negedge clk);
        check("seq1",     if_addr,     32'hBFC0_0008);
        check("seq1_pc2", current_pc2, 32'hBFC0_000C);
        @(negedge clk);
        check("seq2",     if_addr,     32'hBFC0_0010);

        // Predicted redirect to an odd word realigns.
        bp_bus = {1'b1, 32'h8000_0004};
        @(negedge clk); bp_bus = '0;
        check("realign0", if_addr, 32'h8000_0004);
        @(negedge clk);
        check("realign1", if_addr, 32'h8000_0008);
        @(negedge clk);
        check("realign2", if_addr, 32'h8000_0010);

        // Unacked request holds while a branch redirect parks.
        bp_bus = {1'b1, 32'h0000_0100};
        @(negedge clk); bp_bus = '0; if_ack = 1'b0;
        check("hold0", if_addr, 32'h100);
        @(negedge clk);
        check("hold1", if_addr, 32'h100);
        br_bus = {1'b1, 32'h0000_0200};
        @(negedge clk); br_bus = '0;
        check("hold2",       if_addr,        32'h100);
        check("hold2_epoch", 32'(cur_epoch), 32'd1);
        @(negedge clk);
        check("hold3",       if_addr,        32'h100);
        check("hold3_tag",   32'(if_epoch),  32'd0);
        if_ack = 1'b1;
        @(negedge clk);
        check("park_issue",     if_addr,       32'h200);
        check("park_issue_tag", 32'(if_epoch), 32'd1);

        // All three sources at once: exception wins, epoch toggles once.
        ex_bus = {1'b1, 32'hBFC0_0380};
        br_bus = {1'b1, 32'h0000_0400};
        bp_bus = {1'b1, 32'h0000_0500};
        @(negedge clk); ex_bus = '0; br_bus = '0; bp_bus = '0;
        check("simul_addr",  if_addr,        32'hBFC0_0380);
        check("simul_epoch", 32'(cur_epoch), 32'd0);
        check("simul_tag",   32'(if_epoch),  32'd0);

        // Parked bp overwritten by br; later bp is lower and dropped.
        if_ack = 1'b0;
        bp_bus = {1'b1, 32'h0000_0500};
        @(negedge clk); bp_bus = '0; br_bus = {1'b1, 32'h0000_0600};
        @(negedge clk); br_bus = '0; bp_bus = {1'b1, 32'h0000_0700};
        @(negedge clk); bp_bus = '0;
        check("prio_hold", if_addr, 32'hBFC0_0380);
        if_ack = 1'b1;
        @(negedge clk);
        check("prio_addr",  if_addr,        32'h600);
        check("prio_epoch", 32'(cur_epoch), 32'd1);

        // Ack during stall drops req; exception while stalled issues on release.
        bp_bus = {1'b1, 32'h0000_0040};
        @(negedge clk); bp_bus = '0;
        check("stall_base", if_addr, 32'h40);
        stall = 1'b1;
        @(negedge clk);
        check("stall_req0", 32'(if_req), 32'd0);
        if_ack = 1'b0;
        ex_bus = {1'b1, 32'hBFC0_0380};
        @(negedge clk); ex_bus = '0;
        check("stall_req1",  32'(if_req),    32'd0);
        check("stall_epoch", 32'(cur_epoch), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        check("stall_rel",     if_addr,       32'hBFC0_0380);
        check("stall_rel_req", 32'(if_req),   32'd1);
        check("stall_rel_tag", 32'(if_epoch), 32'd0);

        // Reset mid-request with a parked redirect: both abandoned.
        bp_bus = {1'b1, 32'h0000_0900};
        @(negedge clk); bp_bus = '0;
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_req",  32'(if_req), 32'd0);
        check("midrst_addr", if_addr,     RST);
        resetn = 1'b1; if_ack = 1'b1;
        @(negedge clk);
        check("midrst_launch", if_addr,     RST);
        check("midrst_req1",   32'(if_req), 32'd1);

        // Randomized traffic.
        repeat (4000) begin
            resetn = ($urandom_range(0, 199) != 0);
            stall  = ($urandom_range(0, 99) < 25);
            if_ack = ($urandom_range(0, 99) < 60);
            ex_bus = rand_bus(5);
            br_bus = rand_bus(10);
            bp_bus = rand_bus(15);
            @(negedge clk);
        end

        resetn = 1'b1; stall = 1'b0; if_ack = 1'b1;
        ex_bus = '0; br_bus = '0; bp_bus = '0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-address generator at the head of the front end. It holds the architectural fetch PC and presents the PC pair (pc, pc+4) to the branch predictor for lookup. It issues aligned dual-instruction fetch requests to the I-cache over a valid/ack handshake. It merges three redirect sources (exception, resolved branch, predicted branch) by fixed priority, and parks redirects that arrive while a request is stalled on the handshake.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.
- BR_WD, 33, redirect bus width: {enable, target[31:0]}.
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- stall  in  1  back-end stall; blocks launching a new request.
- ex_bus  in  BR_WD  exception/eret redirect {ex_e, ex_target}.
- br_bus  in  BR_WD  resolved-branch redirect {br_e, br_target}. Asserted only after the delay slot has been fetched.
- bp_bus  in  BR_WD  predicted redirect {bp_e, bp_target}. Registered by the predictor one cycle after the hitting PC pair was presented.
- if_req  out  1  fetch request valid.
- if_addr  out  32  fetch address; word-aligned.
- if_ack  in  1  I-cache accepts request this cycle.
- if_epoch  out  1  epoch tag of the current request.
- cur_epoch  out  1  live epoch; the IF stage drops responses whose tag differs.
- current_pc1  out  32  = if_addr, to predictor.
- current_pc2  out  32  = if_addr + 4, to predictor.

## Operation
- Registers: addr (32), req (1), req_epoch (1), epoch (1), pend_v (1), pend_pri (2), pend_pc (32).
- Request handshake:
  - A request is launched in any cycle where !stall and (!req or if_ack).
  - While req & !if_ack, if_addr and if_epoch hold constant regardless of stall or redirects.
  - If if_ack arrives while stall=1, req falls to 0 the next cycle.
- Sequential next address: addr[2]==0 gives addr+8 (full pair); addr[2]==1 gives addr+4 (single, realigns to a pair). Arithmetic is 32-bit and wraps at 2^32.
- Redirect priority per cycle: ex (2) > br (1) > bp (0). Only the highest-priority asserted source is taken; lower sources that cycle are discarded.
- Epoch: epoch toggles in every cycle where ex_e or br_e is asserted (once per cycle, even if both are asserted). bp never toggles epoch.
- Applying a redirect:
  - If a launch occurs this cycle, the launched address is the redirect target. The sequential path and pend are ignored, and pend clears.
  - Otherwise the redirect is written to pend if pend is empty or incoming priority ≥ pend_pri. A lower-priority incoming redirect is dropped.
- Launch address selection, in order: incoming redirect this cycle, then pend_pc if pend_v, then sequential. Consuming pend clears pend_v.
- req_epoch captures the post-toggle epoch value at launch.
- States, implied by (req, pend_v):
  - IDLE (0,0): reset or stalled.
  - BUSY (1,0).
  - BUSY_PEND (1,1).
  - IDLE_PEND (0,1): stalled with a parked redirect.
- A redirect target is never lost across stall or an unacked request except by priority override.
- Reset (resetn=0 at a clk edge):
  - addr = RESET_PC, req = 0, epoch = 0, req_epoch = 0, pend_v = 0, pend_pri = 0, pend_pc = 0.
  - The first cycle after reset launches RESET_PC if !stall.
- Reset mid-request: the outstanding request is abandoned without waiting for if_ack.

## Timing
- Redirect to address: a redirect sampled at edge N, with a launch permitted at N, makes if_addr = target from N+1. Parked redirects issue at the first permitted launch.
- Predictor loop: a pair presented in cycle C produces bp_e in C+1, and the target issues in C+2 at best. The sequential request launched in C+1 is not cancelled here; the downstream invalid flag handles it.
- if_req, if_addr, if_epoch, current_pc1, current_pc2 are direct register outputs (current_pc2 is register+4). There is no combinational path from inputs to outputs.
- cur_epoch reflects the toggle the cycle after ex_e/br_e.
- Throughput: one request per cycle while if_ack=1 and stall=0.

## Test plan
- Reset, stall=0, if_ack=1: if_req=0 during reset. Then if_addr = BFC00000, BFC00008, BFC00010 on consecutive cycles; current_pc2 = if_addr+4.
- Realignment: bp_target=0x8000_0004 with if_ack=1 → next if_addr=80000004, then 80000008, 80000010.
- Unacked request: if_addr=0x100 held with if_ack=0 for 3 cycles; br_e (target 0x200) in cycle 2 → if_addr stays 0x100, cur_epoch toggles. After ack, if_addr=0x200 with if_epoch=1.
- Simultaneous sources: ex (0xBFC00380), br (0x400), bp (0x500) in one launch cycle → if_addr=BFC00380. Epoch toggles exactly once.
- Priority overwrite while parked: if_ack=0; bp (0x500) parks, then br (0x600), then bp (0x700) → after ack, if_addr=0x600.
- Stall: stall=1 during ack at 0x40 → req=0 next cycle. ex_e (0xBFC00380) arrives while stalled; on stall release, if_addr=BFC00380 with the new epoch. Assert resetn=0 mid-request → addr=RESET_PC, req=0, pend_v=0.
